// File: rtl/n1_pkg.sv
// Shared definitions for the n1_core_p slice: opcodes, FSM states, fault codes, flags, field helpers.
// N1_MULDIV_EN decides whether MUL/DIV are legal opcodes.
package n1_pkg;

  localparam logic [3:0] OP_ILL0  = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_PRINT = 4'h7;
  localparam logic [3:0] OP_END   = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JNE   = 4'hB;
  localparam logic [3:0] OP_JLE   = 4'hC;
  localparam logic [3:0] OP_CALL  = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;
  localparam logic [3:0] OP_ILL1  = 4'hF;

  typedef enum logic [1:0] {FETCH, EXEC, HALT, FAULT} state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_REG     = 3'd2;
  localparam logic [2:0] FC_MEM     = 3'd3;
  localparam logic [2:0] FC_STK_OVF = 3'd4;
  localparam logic [2:0] FC_STK_UNF = 3'd5;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic [3:0] f_op(input logic [15:0] inst);
    return inst[15:12];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] inst);
    return inst[11:9];
  endfunction

  function automatic logic [2:0] f_ra(input logic [15:0] inst);
    return inst[8:6];
  endfunction

  function automatic logic [2:0] f_rb(input logic [15:0] inst);
    return inst[5:3];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] inst);
    return inst[7:0];
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
`ifdef N1_MULDIV_EN
    return (op == OP_ILL0) || (op == OP_ILL1);
`else
    return (op == OP_ILL0) || (op == OP_ILL1) || (op == OP_MUL) || (op == OP_DIV);
`endif
  endfunction

  function automatic logic uses_rd(input logic [3:0] op);
    return op inside {OP_MOV, OP_STORE, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP};
  endfunction

  function automatic logic uses_ra(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP};
  endfunction

  function automatic logic uses_rb(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/n1_core_p_if.sv
// Programming port and output strobe bundle between the pin-mapping top and n1_core_p.
interface n1_core_p_if #(
  parameter int unsigned DATA_W = 16
);
  logic              prog_we;
  logic [7:0]        prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              fault;
  logic [2:0]        fault_code;

  modport master (
    output prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, fault, fault_code
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, fault, fault_code
  );
endinterface

// File: rtl/n1_alu.sv
// Combinational ALU for n1_core_p: ADD/SUB/CMP always, MUL/DIV only when N1_MULDIV_EN is defined.
module n1_alu
  import n1_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  flags_t            flags_in,
  output logic [DATA_W-1:0] result,
  output flags_t            flags_out
);
  localparam int unsigned M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    result    = '0;
    flags_out = flags_in;
    case (op)
      OP_ADD: begin
        result      = sum[M:0];
        flags_out.c = sum[DATA_W];
        flags_out.v = (a[M] == b[M]) && (result[M] != a[M]);
        flags_out.n = result[M];
        flags_out.z = (result == '0);
      end
      OP_SUB: begin
        result      = diff[M:0];
        // Zero-extended subtraction: the extra bit is the borrow (a < b).
        flags_out.c = diff[DATA_W];
        flags_out.v = (a[M] != b[M]) && (result[M] != a[M]);
        flags_out.n = result[M];
        flags_out.z = (result == '0);
      end
      OP_CMP: begin
        flags_out.z = (a == b);
        flags_out.n = (a < b);
      end
`ifdef N1_MULDIV_EN
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) begin
          result      = '1;
          flags_out.v = 1'b1;
        end else begin
          result = a / b;
        end
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/n1_core_p.sv
// Parameterised multi-cycle n1 core: FSM, unified memory, register file and call stack.
// Define N1_MULDIV_EN to enable MUL/DIV; otherwise those opcodes fault as illegal.
module n1_core_p
  import n1_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NREGS       = 4,
  parameter int unsigned MEM_DEPTH   = 128,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  n1_core_p_if.slave bus
);
  localparam int unsigned AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned RW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  logic [DATA_W-1:0] mem   [MEM_DEPTH];
  logic [DATA_W-1:0] regs  [NREGS];
  logic [7:0]        stack [STACK_DEPTH];

  state_t            state;
  logic [7:0]        pc;
  logic [SPW-1:0]    sp;
  logic [15:0]       inst;
  flags_t            flags;

  logic [3:0]        op;
  logic [2:0]        rd, ra, rb;
  logic [7:0]        imm;
  logic [7:0]        pc_inc;
  logic [DATA_W-1:0] rd_v, ra_v, rb_v, opa, opb, alu_res;
  flags_t            alu_flags;
  logic              prog_ok;
  logic [2:0]        exec_fc;

  always_comb begin
    op      = f_op(inst);
    rd      = f_rd(inst);
    ra      = f_ra(inst);
    rb      = f_rb(inst);
    imm     = f_imm(inst);
    pc_inc  = pc + 8'd1;
    rd_v    = regs[rd[RW-1:0]];
    ra_v    = regs[ra[RW-1:0]];
    rb_v    = regs[rb[RW-1:0]];
    // CMP compares rd against ra, so its operands sit one field higher than ALU ops.
    opa     = (op == OP_CMP) ? rd_v : ra_v;
    opb     = (op == OP_CMP) ? ra_v : rb_v;
    prog_ok = 32'(bus.prog_addr) < MEM_DEPTH;

    exec_fc = FC_NONE;
    if (op_illegal(op))
      exec_fc = FC_ILLEGAL;
    else if ((uses_rd(op) && 32'(rd) >= NREGS) ||
             (uses_ra(op) && 32'(ra) >= NREGS) ||
             (uses_rb(op) && 32'(rb) >= NREGS))
      exec_fc = FC_REG;
    else if ((op == OP_STORE || op == OP_PRINT) && 32'(imm) >= MEM_DEPTH)
      exec_fc = FC_MEM;
    else if (op == OP_CALL && 32'(sp) == STACK_DEPTH)
      exec_fc = FC_STK_OVF;
    else if (op == OP_RET && sp == '0)
      exec_fc = FC_STK_UNF;
  end

  n1_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (op),
    .a         (opa),
    .b         (opb),
    .flags_in  (flags),
    .result    (alu_res),
    .flags_out (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= '0;
      sp             <= '0;
      inst           <= '0;
      flags          <= '0;
      bus.out_valid  <= 1'b0;
      bus.halted     <= 1'b0;
      bus.fault      <= 1'b0;
      bus.fault_code <= FC_NONE;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      if (bus.prog_we && prog_ok) mem[bus.prog_addr[AW-1:0]] <= bus.prog_data;
      bus.out_data <= prog_ok ? mem[bus.prog_addr[AW-1:0]] : '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (32'(pc) >= MEM_DEPTH) begin
            state          <= FAULT;
            bus.fault      <= 1'b1;
            bus.fault_code <= FC_MEM;
          end else begin
            inst  <= mem[pc[AW-1:0]][15:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          if (exec_fc != FC_NONE) begin
            state          <= FAULT;
            bus.fault      <= 1'b1;
            bus.fault_code <= exec_fc;
          end else begin
            state <= FETCH;
            pc    <= pc_inc;
            case (op)
              OP_MOV:   regs[rd[RW-1:0]] <= DATA_W'(imm);
              OP_STORE: mem[imm[AW-1:0]] <= rd_v;
              OP_PRINT: begin
                bus.out_data  <= mem[imm[AW-1:0]];
                bus.out_valid <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                regs[rd[RW-1:0]] <= alu_res;
                flags            <= alu_flags;
              end
              OP_CMP: flags <= alu_flags;
              OP_JMP: pc <= imm;
              OP_JNE: if (!flags.z) pc <= imm;
              OP_JLE: if (flags.n || flags.z) pc <= imm;
              OP_CALL: begin
                stack[SW'(sp)] <= pc_inc;
                sp             <= sp + SPW'(1);
                pc             <= imm;
              end
              OP_RET: begin
                pc <= stack[SW'(sp - SPW'(1))];
                sp <= sp - SPW'(1);
              end
              OP_END: begin
                state      <= HALT;
                bus.halted <= 1'b1;
                pc         <= pc;
              end
              default: ;
            endcase
          end
        end
        HALT, FAULT: ;
        default: state <= FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_n1_core_p.sv
// Scoreboard bench for n1_core_p: directed programs, PRINT results checked by a decoupled monitor.
module tb_n1_core_p;
  logic clk = 1'b0;
  logic rst_n;

  n1_core_p_if #(.DATA_W(16)) bus ();

  n1_core_p #(
    .DATA_W      (16),
    .NREGS       (4),
    .MEM_DEPTH   (128),
    .STACK_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  string       exp_name[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_print(input string name, input logic [15:0] v);
    exp_q.push_back(v);
    exp_name.push_back(name);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_print: got 0x%0h, expected no output", bus.out_data);
      end else begin
        chk(exp_name.pop_front(), 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [15:0] i_ri(input logic [3:0] op, input int r, input int a8);
    return {op, 3'(r), 1'b0, 8'(a8)};
  endfunction

  function automatic logic [15:0] i_rrr(input logic [3:0] op, input int d, input int a, input int b);
    return {op, 3'(d), 3'(a), 3'(b), 3'b000};
  endfunction

  task automatic run(input string name, input logic [15:0] prog[$], input int budget, output int cyc);
    rst_n = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'(i);
      bus.prog_data = prog[i];
      @(negedge clk);
    end
    bus.prog_we = 1'b0;
    @(negedge clk);
    chk({name, "_rst_halted"}, 32'(bus.halted), 32'd0);
    chk({name, "_rst_fault"},  32'(bus.fault), 32'd0);
    chk({name, "_rst_code"},   32'(bus.fault_code), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    while (bus.halted !== 1'b1 && bus.fault !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.halted !== 1'b1 && bus.fault !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no halt/fault after %0d cycles, expected a stop", name, cyc);
    end
  endtask

  task automatic finish_chk(input string name, input int cyc, input int exp_cyc,
                            input logic exp_halt, input logic [2:0] exp_code);
    chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    repeat (3) @(negedge clk);
    chk({name, "_halted"}, 32'(bus.halted), 32'(exp_halt));
    chk({name, "_fault"},  32'(bus.fault), 32'(exp_code != 3'd0));
    chk({name, "_code"},   32'(bus.fault_code), 32'(exp_code));
    chk({name, "_pending_prints"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_name.delete();
  endtask

  initial begin
    logic [15:0] p[$];
    int          cyc;

    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;

    // 5 + 3 = 8, six instructions = 12 cycles
    p = '{i_ri(4'h1, 0, 5), i_ri(4'h1, 1, 3), i_rrr(4'h3, 2, 0, 1),
          i_ri(4'h2, 2, 64), i_ri(4'h7, 0, 64), 16'h8000};
    expect_print("basic_print", 16'd8);
    run("basic", p, 200, cyc);
    finish_chk("basic", cyc, 12, 1'b1, 3'd0);

    // 0 - 1 = 0xFFFF: N=1 Z=0 C=1 V=0
    p = '{i_ri(4'h1, 0, 0), i_ri(4'h1, 1, 1), i_rrr(4'h4, 2, 0, 1),
          i_ri(4'h2, 2, 64), i_ri(4'h7, 0, 64), 16'h8000};
    expect_print("sub_print", 16'hFFFF);
    run("sub", p, 200, cyc);
    chk("sub_flags", 32'({dut.flags.n, dut.flags.z, dut.flags.c, dut.flags.v}), 32'b1010);
    finish_chk("sub", cyc, 12, 1'b1, 3'd0);

    // 0x80 doubled 8x = 0x8000; -1 -> 0x7FFF; +1 -> 0x8000 with N=1 Z=0 C=0 V=1
    p = '{i_ri(4'h1, 0, 8'h80), i_ri(4'h1, 3, 1)};
    for (int i = 0; i < 8; i++) p.push_back(i_rrr(4'h3, 0, 0, 0));
    p.push_back(i_rrr(4'h4, 1, 0, 3));
    p.push_back(i_rrr(4'h3, 2, 1, 3));
    p.push_back(i_ri(4'h2, 2, 64));
    p.push_back(i_ri(4'h7, 0, 64));
    p.push_back(16'h8000);
    expect_print("ovf_print", 16'h8000);
    run("ovf", p, 200, cyc);
    chk("ovf_flags", 32'({dut.flags.n, dut.flags.z, dut.flags.c, dut.flags.v}), 32'b1001);
    finish_chk("ovf", cyc, 30, 1'b1, 3'd0);

    // CALL 3 -> MOV r0,9; STORE; RET -> PRINT at pc 1
    p = '{i_ri(4'hD, 0, 3), i_ri(4'h7, 0, 64), 16'h8000,
          i_ri(4'h1, 0, 9), i_ri(4'h2, 0, 64), 16'hE000};
    expect_print("call_print", 16'd9);
    run("call", p, 200, cyc);
    finish_chk("call", cyc, 12, 1'b1, 3'd0);

    // Three nested CALLs with STACK_DEPTH=2: third faults at pc 4
    p = '{i_ri(4'hD, 0, 2), 16'h8000, i_ri(4'hD, 0, 4), 16'h8000,
          i_ri(4'hD, 0, 6), 16'h8000, 16'h8000};
    run("nest", p, 200, cyc);
    chk("nest_pc", 32'(dut.pc), 32'd4);
    finish_chk("nest", cyc, 6, 1'b0, 3'd4);

    p = '{16'hE000};
    run("ret0", p, 200, cyc);
    finish_chk("ret0", cyc, 2, 1'b0, 3'd5);

    p = '{i_ri(4'h1, 5, 1)};
    run("badreg", p, 200, cyc);
    finish_chk("badreg", cyc, 2, 1'b0, 3'd2);

    p = '{16'hF000};
    run("illegal", p, 200, cyc);
    finish_chk("illegal", cyc, 2, 1'b0, 3'd1);

    p = '{i_ri(4'h2, 0, 200)};
    run("st_oob", p, 200, cyc);
    finish_chk("st_oob", cyc, 2, 1'b0, 3'd3);

    // Jump past memory end: fault raised on the following fetch
    p = '{i_ri(4'hA, 0, 130)};
    run("pc_oob", p, 200, cyc);
    chk("pc_oob_pc", 32'(dut.pc), 32'd130);
    finish_chk("pc_oob", cyc, 3, 1'b0, 3'd3);

    p = '{i_ri(4'h1, 0, 6), i_ri(4'h1, 1, 7), i_rrr(4'h5, 2, 0, 1),
          i_ri(4'h2, 2, 64), i_ri(4'h7, 0, 64), 16'h8000};
`ifdef N1_MULDIV_EN
    expect_print("mul_print", 16'd42);
    run("mul", p, 200, cyc);
    finish_chk("mul", cyc, 12, 1'b1, 3'd0);
`else
    run("mul", p, 200, cyc);
    finish_chk("mul", cyc, 6, 1'b0, 3'd1);
`endif

    p = '{i_ri(4'h1, 0, 7), i_ri(4'h1, 1, 0), i_rrr(4'h6, 2, 0, 1),
          i_ri(4'h2, 2, 64), i_ri(4'h7, 0, 64), 16'h8000};
`ifdef N1_MULDIV_EN
    expect_print("div0_print", 16'hFFFF);
    run("div0", p, 200, cyc);
    chk("div0_flags", 32'({dut.flags.n, dut.flags.z, dut.flags.c, dut.flags.v}), 32'b0001);
    finish_chk("div0", cyc, 12, 1'b1, 3'd0);
`else
    run("div0", p, 200, cyc);
    finish_chk("div0", cyc, 6, 1'b0, 3'd1);
`endif

    // Count r0 up to 4: 3 + 4*3 + 3 = 18 instructions
    p = '{i_ri(4'h1, 0, 0), i_ri(4'h1, 1, 1), i_ri(4'h1, 3, 4),
          i_rrr(4'h3, 0, 0, 1), i_rrr(4'h9, 0, 3, 0), i_ri(4'hB, 0, 3),
          i_ri(4'h2, 0, 64), i_ri(4'h7, 0, 64), 16'h8000};
    expect_print("loop_print", 16'd4);
    run("loop", p, 200, cyc);
    finish_chk("loop", cyc, 36, 1'b1, 3'd0);

    // Restart the loop, abort it mid-run, then exercise the programming port
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    rst_n         = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'd72;
    bus.prog_data = 16'h7272;
    @(negedge clk);
    chk("mid_rst_halted", 32'(bus.halted), 32'd0);
    chk("mid_rst_fault",  32'(bus.fault), 32'd0);
    chk("mid_rst_valid",  32'(bus.out_valid), 32'd0);
    bus.prog_addr = 8'd10;
    bus.prog_data = 16'h5A5A;
    @(negedge clk);
    bus.prog_data = 16'hA5A5;
    @(negedge clk);
    chk("rd_during_wr", 32'(bus.out_data), 32'h5A5A);
    bus.prog_we = 1'b0;
    @(negedge clk);
    chk("readback", 32'(bus.out_data), 32'hA5A5);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 8'd200;
    bus.prog_data = 16'h1111;
    @(negedge clk);
    chk("oob_readback", 32'(bus.out_data), 32'h0);
    bus.prog_we   = 1'b0;
    bus.prog_addr = 8'd72;
    @(negedge clk);
    chk("oob_no_alias", 32'(bus.out_data), 32'h7272);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/n1_core_p.md
Name: n1_core_p

Overview:
- Parameterised successor to the n1 single-cycle CPU.
- Multi-cycle fetch/execute core with a generalised data width, register-file size, memory depth and hardware call-stack depth.
- Adds explicit halt and fault states, stack bounds checking, divide-by-zero handling and an output-valid strobe.
- Sits between the tt_um top-level pin mapping and the unified program/data memory it owns; the memory is loaded through a programming port while in reset.

Parameters:
- DATA_W, 16: register/memory word width; legal range 16..32; instructions always occupy bits [15:0].
- NREGS, 4: number of general-purpose registers; legal range 2..8.
- MEM_DEPTH, 128: words of unified memory; legal range 16..256.
- STACK_DEPTH, 16: call-stack entries.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset. Synchronous, active-low.
- prog_we, input, 1: memory write enable; honoured only while rst_n=0.
- prog_addr, input, 8: program/readback address.
- prog_data, input, DATA_W: word written when prog_we=1 during reset.
- out_data, output, DATA_W: last PRINT value, or readback word during reset.
- out_valid, output, 1: one-cycle pulse per PRINT.
- halted, output, 1: core executed END.
- fault, output, 1: core stopped on an error.
- fault_code, output, 3: cause of the fault.

Behaviour:
- Reset (rst_n=0, sampled on clk):
  - pc, sp, registers, N/Z/C/V, out_valid, halted, fault and fault_code are all cleared to 0.
  - State goes to FETCH.
  - If prog_we=1, mem[prog_addr] <= prog_data.
  - out_data <= mem[prog_addr], registered one cycle; a read and a write to the same address return the old word.
  - prog_addr >= MEM_DEPTH: writes are ignored and readback returns 0.
- State machine:
  - FETCH: inst <= mem[pc]; go to EXEC.
  - EXEC: decode and execute; next state is FETCH, HALT or FAULT.
  - HALT and FAULT are sticky until reset.
  - Every instruction takes exactly 2 cycles.
- Opcodes, inst[15:12]:
  - 0001 MOV: rd=inst[11:9] <= zero-extended inst[7:0].
  - 0010 STORE: mem[inst[7:0]] <= rd.
  - 0111 PRINT: out_data <= mem[inst[7:0]]; out_valid=1 for the following cycle.
  - 0011 ADD: rd <= ra + rb, with ra=inst[8:6] and rb=inst[5:3]. C = carry out of bit DATA_W-1. V = signed overflow. N = MSB of result. Z = (result == 0).
  - 0100 SUB: rd <= ra - rb. C=1 on borrow (ra < rb unsigned). N, Z, V as for ADD.
  - 0101 MUL: rd <= low DATA_W bits of ra*rb. Flags unchanged.
  - 0110 DIV: unsigned; rd <= ra/rb. If rb=0: rd <= all-ones and V=1.
  - 1001 CMP: Z = (rd == ra); N = (rd < ra) unsigned. C and V unchanged.
  - 1010 JMP: pc <= inst[7:0].
  - 1011 JNE: jump if !Z, else pc+1.
  - 1100 JLE: jump if N|Z, else pc+1.
  - 1101 CALL: stack[sp] <= pc+1; sp++; pc <= inst[7:0].
  - 1110 RET: pc <= stack[sp-1]; sp--.
  - 1000 END: go to HALT; pc holds its value.
  - All other instructions: pc <= pc+1.
- Faults: state goes to FAULT, fault=1, and pc and registers are preserved.
  - fault_code 1: illegal opcode (0000, 1111).
  - fault_code 2: register index >= NREGS.
  - fault_code 3: memory address >= MEM_DEPTH, including pc.
  - fault_code 4: CALL with sp == STACK_DEPTH.
  - fault_code 5: RET with sp == 0.
- pc is 8 bits wide and wraps 255 -> 0. Since pc >= MEM_DEPTH raises code 3, execution never runs off the end silently.
- A register write and a flag update in the same EXEC take effect together on the EXEC edge.
- Reset during any state aborts the instruction with no partial memory write; stack contents are not cleared.

Optional Feature:
- N1_MULDIV_EN:
  - Defined: MUL and DIV are implemented as above.
  - Undefined: no multiplier or divider is synthesised; opcodes 0101 and 0110 raise fault_code 1.

Decomposition:
- Package n1_pkg holds:
  - opcode localparams (OP_MOV ... OP_RET);
  - state enum (FETCH, EXEC, HALT, FAULT);
  - fault-code constants;
  - instruction field-slice helper functions.
- Sub-module n1_alu: combinational; ADD/SUB/MUL/DIV plus the N/Z/C/V next-value logic. Its MUL/DIV logic is gated by N1_MULDIV_EN.
- FSM, memory, register file and stack stay in n1_core_p.

Test Plan:
- Load MOV r0,#5; MOV r1,#3; ADD r2,r0,r1; STORE r2,#64; PRINT #64; END. Expect out_data=8, one out_valid pulse, halted=1 after 12 cycles.
- Loop test: MOV r0,#0; MOV r1,#1; MOV r3,#4; ADD r0,r0,r1; CMP r0,r3; JNE 3; then store and print r0. Expect 4 printed, then halted.
- Flag test: SUB with r0=0 and r1=1. Expect rd=0xFFFF (DATA_W=16) with N=1, C=1, Z=0. ADD 0x7FFF+1 -> V=1.
- Stack test: STACK_DEPTH=2 with nested CALLs three deep. Expect fault_code=4. A lone RET at pc 0 -> fault_code=5.
- Error cases:
  - DIV by r=0 -> rd=0xFFFF, V=1.
  - MOV to r5 with NREGS=4 -> fault_code=2.
  - Without N1_MULDIV_EN, MUL -> fault_code=1.
- Reset test: reset mid-program, write 0xA5A5 to address 10, and read it back. Expect out_data=0xA5A5 one cycle later; halted and fault cleared.
